// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: parity codes, FSM states,
// and the data-bit-count clamp.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'd0,
        PAR_EVEN     = 2'd1,
        PAR_ODD      = 2'd2,
        PAR_NONE_ALT = 2'd3
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam logic [3:0] NBITS_MIN = 4'd5;

    // Requests outside NBITS_MIN..max_bits fall back to the full word width.
    function automatic logic [3:0] clamp_nbits(input logic [3:0] req,
                                               input logic [3:0] max_bits);
        if (req < NBITS_MIN || req > max_bits) begin
            return max_bits;
        end
        return req;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Show-ahead input FIFO for the UART transmitter. The head word is always
// visible on rdata; push while full and pop while empty are ignored.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic [DATA_W-1:0]               wdata,
    input  logic                            pop,
    output logic [DATA_W-1:0]               rdata,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH):0]     count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: input FIFO, internal baud divider and a
// frame FSM (start, 5..DATA_W data bits LSB first, optional parity, 1/2 stop).
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DIV_W-1:0]                baud_div,
    input  logic [3:0]                      nbits,
    input  logic [1:0]                      parity,
    input  logic                            stop2,
    input  logic [DATA_W-1:0]               s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic                            txd,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam logic [3:0] NBITS_MAX = 4'(DATA_W);

    tx_state_t          state_q, state_d;
    logic [DIV_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [3:0]         nbits_q, nbits_d;
    logic [3:0]         bit_idx_q, bit_idx_d;
    parity_t            par_q, par_d;
    logic               stop2_q, stop2_d;
    logic               stop_cnt_q, stop_cnt_d;
    logic               par_acc_q, par_acc_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic               txd_q, txd_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic [DATA_W-1:0]  fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               bit_end;
    logic               load_frame;
    logic               parity_on;

    assign s_ready   = !fifo_full;
    assign fifo_push = s_valid && s_ready;
    assign txd       = txd_q;
    assign busy      = (state_q != ST_IDLE);
    assign bit_end   = (baud_cnt_q == div_q);
    assign parity_on = (par_q == PAR_EVEN) || (par_q == PAR_ODD);

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (s_data),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Frame sequencing: next state, baud timing, shifting and the next line level.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        div_d      = div_q;
        nbits_d    = nbits_q;
        bit_idx_d  = bit_idx_q;
        par_d      = par_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        par_acc_d  = par_acc_q;
        shreg_d    = shreg_q;
        txd_d      = txd_q;
        fifo_pop   = 1'b0;
        load_frame = 1'b0;

        if (state_q != ST_IDLE) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + DIV_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load_frame = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    par_acc_d = par_acc_q ^ shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    if (bit_idx_q == nbits_q - 4'd1) begin
                        state_d    = parity_on ? ST_PARITY : ST_STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else if (!fifo_empty) begin
                        load_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shared by IDLE and end-of-STOP so back-to-back frames re-latch config.
        if (load_frame) begin
            fifo_pop   = 1'b1;
            shreg_d    = fifo_head;
            div_d      = baud_div;
            nbits_d    = clamp_nbits(nbits, NBITS_MAX);
            par_d      = parity_t'(parity);
            stop2_d    = stop2;
            state_d    = ST_START;
            baud_cnt_d = '0;
            bit_idx_d  = '0;
            par_acc_d  = 1'b0;
            stop_cnt_d = 1'b0;
        end

        // Line level follows the next state so txd_q changes on the same edge as state_q.
        case (state_d)
            ST_IDLE:   txd_d = 1'b1;
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shreg_d[0];
            ST_PARITY: txd_d = par_acc_d ^ (par_d == PAR_ODD);
            ST_STOP:   txd_d = 1'b1;
            default:   txd_d = 1'b1;
        endcase
    end

    // Transmitter state registers; reset abandons any frame and idles the line high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            div_q      <= '0;
            nbits_q    <= NBITS_MAX;
            bit_idx_q  <= '0;
            par_q      <= PAR_NONE;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            par_acc_q  <= 1'b0;
            shreg_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            nbits_q    <= nbits_d;
            bit_idx_q  <= bit_idx_d;
            par_q      <= par_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            par_acc_q  <= par_acc_d;
            shreg_q    <= shreg_d;
            txd_q      <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: expected line waveforms come from a
// frame-level model built out of the frame format rules.
module tb_uart_tx_param;

    localparam int DATA_W     = 8;
    localparam int DIV_W      = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [DIV_W-1:0]  baud_div;
    logic [3:0]        nbits;
    logic [1:0]        parity;
    logic              stop2;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              txd;
    logic              busy;
    logic [CW-1:0]     fifo_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    bit exp_txd[$];
    bit exp_busy[$];
    bit got_txd[$];
    bit got_busy[$];
    logic [CW-1:0] first_count;

    uart_tx_param #(
        .DATA_W     (DATA_W),
        .DIV_W      (DIV_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_div   (baud_div),
        .nbits      (nbits),
        .parity     (parity),
        .stop2      (stop2),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Reference model: one frame as a list of line levels, each held div+1 cycles.
    function automatic void add_frame(input logic [DATA_W-1:0] data, input int div,
                                      input int nb, input int par, input bit s2);
        int n;
        bit p;
        bit bits[$];
        logic [DATA_W-1:0] d;
        n = (nb < 5 || nb > DATA_W) ? DATA_W : nb;
        d = data;
        p = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(d[0]);
            p = p ^ d[0];
            d = d >> 1;
        end
        if (par == 1) bits.push_back(p);
        else if (par == 2) bits.push_back(!p);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[i]) begin
            repeat (div + 1) begin
                exp_txd.push_back(bits[i]);
                exp_busy.push_back(1'b1);
            end
        end
    endfunction

    function automatic void add_idle(input int n);
        repeat (n) begin
            exp_txd.push_back(1'b1);
            exp_busy.push_back(1'b0);
        end
    endfunction

    function automatic void clear_exp();
        exp_txd.delete();
        exp_busy.delete();
    endfunction

    function automatic int count_ones(input bit q[$]);
        int c = 0;
        foreach (q[i]) c += int'(q[i]);
        return c;
    endfunction

    task automatic set_cfg(input int div, input int nb, input int par, input bit s2);
        baud_div = DIV_W'(div);
        nbits    = 4'(nb);
        parity   = 2'(par);
        stop2    = s2;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic capture(input int n);
        got_txd.delete();
        got_busy.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) first_count = fifo_count;
            got_txd.push_back(txd);
            got_busy.push_back(busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({txd, busy, s_ready} !== 3'b101 || fifo_count !== CW'(0))
            $display("FAIL reset_state: txd=%b busy=%b s_ready=%b count=%0d, expected 1 0 1 0",
                     txd, busy, s_ready, fifo_count);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        int bad;
        set_cfg(3, 8, 0, 0);
        clear_exp();
        add_idle(1);
        add_frame(8'hA5, 3, 8, 0, 1'b0);
        add_idle(2);
        push_word(8'hA5);
        capture(exp_txd.size());
        total_cnt++;
        if (first_count !== CW'(1))
            $display("FAIL basic_latency_count: count=%0d expected 1", first_count);
        else pass_cnt++;
        bad = -1;
        foreach (exp_txd[i]) if (bad < 0 && got_txd[i] !== exp_txd[i]) bad = i;
        total_cnt++;
        if (bad >= 0) $display("FAIL basic_txd: cycle %0d got %b expected %b", bad, got_txd[bad], exp_txd[bad]);
        else pass_cnt++;
        bad = -1;
        foreach (exp_busy[i]) if (bad < 0 && got_busy[i] !== exp_busy[i]) bad = i;
        total_cnt++;
        if (bad >= 0) $display("FAIL basic_busy: cycle %0d got %b expected %b", bad, got_busy[bad], exp_busy[bad]);
        else pass_cnt++;
        total_cnt++;
        if (count_ones(got_busy) != 40)
            $display("FAIL basic_busy_len: got %0d cycles expected 40", count_ones(got_busy));
        else pass_cnt++;
    endtask

    task automatic test_parity();
        int bad;
        for (int par = 1; par <= 2; par++) begin
            set_cfg(1, 7, par, 0);
            clear_exp();
            add_idle(1);
            add_frame(8'h55, 1, 7, par, 1'b0);
            add_idle(2);
            push_word(8'h55);
            capture(exp_txd.size());
            bad = -1;
            foreach (exp_txd[i]) if (bad < 0 && got_txd[i] !== exp_txd[i]) bad = i;
            total_cnt++;
            if (bad >= 0) $display("FAIL parity%0d_txd: cycle %0d got %b expected %b", par, bad, got_txd[bad], exp_txd[bad]);
            else pass_cnt++;
            total_cnt++;
            if (got_txd[17] !== (par == 2))
                $display("FAIL parity%0d_bit: got %b expected %b", par, got_txd[17], (par == 2));
            else pass_cnt++;
            total_cnt++;
            if (count_ones(got_busy) != 20)
                $display("FAIL parity%0d_len: got %0d expected 20", par, count_ones(got_busy));
            else pass_cnt++;
        end
    endtask

    task automatic test_short_frame();
        bit want[10] = '{1, 0, 1, 1, 0, 0, 0, 1, 1, 1};
        int bad;
        set_cfg(0, 5, 0, 1);
        clear_exp();
        add_idle(1);
        add_frame(8'hE3, 0, 5, 0, 1'b1);
        add_idle(2);
        push_word(8'hE3);
        capture(exp_txd.size());
        bad = -1;
        for (int i = 0; i < 10; i++) if (bad < 0 && got_txd[i] !== want[i]) bad = i;
        total_cnt++;
        if (bad >= 0) $display("FAIL short_frame_fixed: cycle %0d got %b expected %b", bad, got_txd[bad], want[bad]);
        else pass_cnt++;
        bad = -1;
        foreach (exp_busy[i]) if (bad < 0 && got_busy[i] !== exp_busy[i]) bad = i;
        total_cnt++;
        if (bad >= 0) $display("FAIL short_frame_busy: cycle %0d got %b expected %b", bad, got_busy[bad], exp_busy[bad]);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] w[6];
        int idx = 0;
        int bad = -1;
        int ready_bad = -1;
        bit saw_full = 1'b0;
        bit snap;
        set_cfg(2, 8, 0, 0);
        clear_exp();
        add_idle(2);
        foreach (w[i]) begin
            w[i] = DATA_W'($urandom);
            add_frame(w[i], 2, 8, 0, 1'b0);
        end
        add_idle(2);
        got_txd.delete();
        got_busy.delete();
        for (int i = 0; i < exp_txd.size(); i++) begin
            @(negedge clk);
            got_txd.push_back(txd);
            got_busy.push_back(busy);
            if (ready_bad < 0 && s_ready !== (fifo_count != CW'(FIFO_DEPTH))) ready_bad = i;
            if (fifo_count == CW'(FIFO_DEPTH) && s_ready === 1'b0) saw_full = 1'b1;
            if (idx < 6) begin
                s_valid = 1'b1;
                s_data  = w[idx];
            end else begin
                s_valid = 1'b0;
            end
            snap = s_valid && s_ready;
            @(posedge clk);
            if (snap) idx++;
        end
        #1;
        s_valid = 1'b0;
        total_cnt++;
        if (idx != 6) $display("FAIL b2b_accepted: got %0d words expected 6", idx);
        else pass_cnt++;
        total_cnt++;
        if (ready_bad >= 0) $display("FAIL b2b_ready_rule: cycle %0d s_ready disagrees with count", ready_bad);
        else pass_cnt++;
        total_cnt++;
        if (!saw_full) $display("FAIL b2b_full: got no full cycle expected count=4 with s_ready=0");
        else pass_cnt++;
        foreach (exp_txd[i]) if (bad < 0 && got_txd[i] !== exp_txd[i]) bad = i;
        total_cnt++;
        if (bad >= 0) $display("FAIL b2b_txd: cycle %0d got %b expected %b", bad, got_txd[bad], exp_txd[bad]);
        else pass_cnt++;
        bad = -1;
        foreach (exp_busy[i]) if (bad < 0 && got_busy[i] !== exp_busy[i]) bad = i;
        total_cnt++;
        if (bad >= 0) $display("FAIL b2b_busy: cycle %0d got %b expected %b", bad, got_busy[bad], exp_busy[bad]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        logic [DATA_W-1:0] w0;
        int bad = -1;
        w0 = DATA_W'($urandom);
        set_cfg(3, 8, 0, 0);
        push_word(w0);
        push_word(DATA_W'($urandom));
        push_word(DATA_W'($urandom));
        repeat (16) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1 || fifo_count !== CW'(2) || txd !== w0[3])
            $display("FAIL midrst_pre: busy=%b count=%0d txd=%b expected 1 2 %b", busy, fifo_count, txd, w0[3]);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({txd, busy, s_ready} !== 3'b101 || fifo_count !== CW'(0))
            $display("FAIL midrst_async: txd=%b busy=%b s_ready=%b count=%0d expected 1 0 1 0",
                     txd, busy, s_ready, fifo_count);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        clear_exp();
        add_idle(1);
        add_frame(8'h3C, 3, 8, 0, 1'b0);
        add_idle(2);
        push_word(8'h3C);
        capture(exp_txd.size());
        foreach (exp_txd[i]) if (bad < 0 && (got_txd[i] !== exp_txd[i] || got_busy[i] !== exp_busy[i])) bad = i;
        total_cnt++;
        if (bad >= 0) $display("FAIL midrst_after: cycle %0d got txd=%b busy=%b expected %b %b",
                               bad, got_txd[bad], got_busy[bad], exp_txd[bad], exp_busy[bad]);
        else pass_cnt++;
    endtask

    task automatic test_config_change();
        logic [DATA_W-1:0] w0, w1;
        int bad = -1;
        w0 = DATA_W'($urandom);
        w1 = DATA_W'($urandom);
        set_cfg(3, 8, 0, 0);
        clear_exp();
        add_frame(w0, 3, 8, 0, 1'b0);
        add_frame(w1, 1, 8, 1, 1'b0);
        add_idle(2);
        push_word(w0);
        push_word(w1);
        got_txd.delete();
        got_busy.delete();
        for (int i = 0; i < exp_txd.size(); i++) begin
            @(negedge clk);
            got_txd.push_back(txd);
            got_busy.push_back(busy);
            if (i == 8) begin
                baud_div = DIV_W'(1);
                parity   = 2'd1;
            end
        end
        foreach (exp_txd[i]) if (bad < 0 && (got_txd[i] !== exp_txd[i] || got_busy[i] !== exp_busy[i])) bad = i;
        total_cnt++;
        if (bad >= 0) $display("FAIL cfg_change: cycle %0d got txd=%b busy=%b expected %b %b",
                               bad, got_txd[bad], got_busy[bad], exp_txd[bad], exp_busy[bad]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int div, nb, par, bad;
        bit s2;
        logic [DATA_W-1:0] d;
        for (int k = 0; k < 8; k++) begin
            div = int'($urandom_range(0, 3));
            nb  = int'($urandom_range(0, 15));
            par = int'($urandom_range(0, 3));
            s2  = 1'($urandom);
            d   = DATA_W'($urandom);
            set_cfg(div, nb, par, s2);
            clear_exp();
            add_idle(1);
            add_frame(d, div, nb, par, s2);
            add_idle(2);
            push_word(d);
            capture(exp_txd.size());
            bad = -1;
            foreach (exp_txd[i]) if (bad < 0 && (got_txd[i] !== exp_txd[i] || got_busy[i] !== exp_busy[i])) bad = i;
            total_cnt++;
            if (bad >= 0) $display("FAIL random%0d (div=%0d nb=%0d par=%0d s2=%0d d=%h): cycle %0d got txd=%b busy=%b expected %b %b",
                                   k, div, nb, par, s2, d, bad, got_txd[bad], got_busy[bad], exp_txd[bad], exp_busy[bad]);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        baud_div = '0;
        nbits    = 4'd8;
        parity   = 2'd0;
        stop2    = 1'b0;
        test_reset();
        test_basic_frame();
        test_parity();
        test_short_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_config_change();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
